cr_rd_arbiter: RTL and testbench

CR_RD_ARBITER -- requirements
Module: cr_rd_arbiter

---
 rtl/cr_rd_arbiter.sv | 118 +++++++++++
 tb/tb_cr_rd_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_rd_arbiter.sv
// Credit-based round-robin read arbiter: two address streams share one RAM read port and
// read data returns through per-channel show-ahead FIFOs sized to the credit count.
module cr_rd_arbiter #(
  parameter int unsigned CREDITS    = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  output logic        ram_rd_en,
  output logic [7:0]  ram_rd_addr,
  input  logic [15:0] ram_rd_data,
  output logic [15:0] m0_tdata,
  output logic        m0_tvalid,
  input  logic        m0_tready,
  output logic [15:0] m1_tdata,
  output logic        m1_tvalid,
  input  logic        m1_tready,
  output logic        fifo0_overflow,
  output logic        fifo1_overflow
);
  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned PW = $clog2(CREDITS);
  localparam logic [CW-1:0] CreditMax = CW'(CREDITS);
  localparam logic [PW-1:0] PtrLast   = PW'(CREDITS - 1);

  logic [1:0]            s_valid, m_ready, m_valid, elig, gnt, push, pop, wr_en;
  logic [CW-1:0]         credit_q [2];
  logic [CW-1:0]         count_q  [2];
  logic [PW-1:0]         wr_ptr_q [2];
  logic [PW-1:0]         rd_ptr_q [2];
  logic [15:0]           mem_q    [2][CREDITS];
  logic [15:0]           head     [2];
  logic                  last_grant_q;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_ch_q;
  logic [1:0]            ovf_q;

  assign s_valid = {s1_tvalid, s0_tvalid};
  assign m_ready = {m1_tready, m0_tready};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      elig[c]    = s_valid[c] && (credit_q[c] != '0);
      m_valid[c] = !reset_p && (count_q[c] != '0);
      pop[c]     = m_valid[c] && m_ready[c];
      push[c]    = tag_vld_q[RD_LATENCY-1] && (tag_ch_q[RD_LATENCY-1] == 1'(c));
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      wr_en[c]   = push[c] && ((count_q[c] != CreditMax) || pop[c]);
      head[c]    = m_valid[c] ? mem_q[c][rd_ptr_q[c]] : 16'h0000;
    end
  end

  // last_grant_q = 1 means channel 1 was served last, so channel 0 wins a tie.
  always_comb begin
    gnt = 2'b00;
    if (!reset_p) begin
      if (elig == 2'b11) gnt = last_grant_q ? 2'b01 : 2'b10;
      else               gnt = elig;
    end
  end

  assign s0_tready      = gnt[0];
  assign s1_tready      = gnt[1];
  assign ram_rd_en      = |gnt;
  assign ram_rd_addr    = gnt[1] ? s1_tdata : (gnt[0] ? s0_tdata : 8'h00);
  assign m0_tvalid      = m_valid[0];
  assign m1_tvalid      = m_valid[1];
  assign m0_tdata       = head[0];
  assign m1_tdata       = head[1];
  assign fifo0_overflow = ovf_q[0];
  assign fifo1_overflow = ovf_q[1];

  always_ff @(posedge clk) begin
    if (reset_p) begin
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_ch_q     <= '0;
      ovf_q        <= '0;
      for (int c = 0; c < 2; c++) begin
        credit_q[c] <= CreditMax;
        count_q[c]  <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
    end else begin
      if (|gnt) last_grant_q <= gnt[1];
      tag_vld_q[0] <= |gnt;
      tag_ch_q[0]  <= gnt[1];
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
      end
      for (int c = 0; c < 2; c++) begin
        if (gnt[c] != pop[c]) begin
          credit_q[c] <= gnt[c] ? credit_q[c] - 1'b1 : credit_q[c] + 1'b1;
        end
        if (wr_en[c] != pop[c]) begin
          count_q[c] <= wr_en[c] ? count_q[c] + 1'b1 : count_q[c] - 1'b1;
        end
        if (wr_en[c]) wr_ptr_q[c] <= (wr_ptr_q[c] == PtrLast) ? '0 : wr_ptr_q[c] + 1'b1;
        if (pop[c])   rd_ptr_q[c] <= (rd_ptr_q[c] == PtrLast) ? '0 : rd_ptr_q[c] + 1'b1;
        if (push[c] && !wr_en[c]) ovf_q[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (wr_en[c] && !reset_p) mem_q[c][wr_ptr_q[c]] <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_cr_rd_arbiter.sv
// Scoreboard bench for cr_rd_arbiter: RAM returns 16'h1000 + address one cycle after a read.
module tb_cr_rd_arbiter;
  localparam int unsigned CREDITS    = 4;
  localparam int unsigned RD_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic [7:0]  s0_tdata = '0, s1_tdata = '0;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tready, s1_tready;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [15:0] ram_rd_data = 16'hDEAD;
  logic [15:0] m0_tdata, m1_tdata;
  logic        m0_tvalid, m1_tvalid;
  logic        m0_tready = 1'b0, m1_tready = 1'b0;
  logic        fifo0_overflow, fifo1_overflow;

  cr_rd_arbiter #(.CREDITS(CREDITS), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset_p(reset_p),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
    .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
    .fifo0_overflow(fifo0_overflow), .fifo1_overflow(fifo1_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rd_data <= ram_rd_en ? 16'h1000 + {8'h00, ram_rd_addr} : 16'hDEAD;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stimulus state shared with the driver and monitor.
  logic [7:0]  srcq [2][$];
  logic [15:0] expq [2][$];
  int          s_prob [2] = '{0, 0};
  int          m_prob [2] = '{0, 0};
  logic [1:0]  hs = '0;
  int          acc [2] = '{0, 0};
  int          outst [2] = '{0, 0};
  int          last_g = 1;

  // Driver: retire the head accepted at the previous edge, then present new values.
  initial begin
    logic [7:0] tmp;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) if (hs[c] && srcq[c].size() > 0) tmp = srcq[c].pop_front();
      s0_tvalid = (srcq[0].size() > 0) && ($urandom_range(0, 99) < s_prob[0]);
      s1_tvalid = (srcq[1].size() > 0) && ($urandom_range(0, 99) < s_prob[1]);
      s0_tdata  = (srcq[0].size() > 0) ? srcq[0][0] : 8'h00;
      s1_tdata  = (srcq[1].size() > 0) ? srcq[1][0] : 8'h00;
      m0_tready = $urandom_range(0, 99) < m_prob[0];
      m1_tready = $urandom_range(0, 99) < m_prob[1];
    end
  end

  // Monitor: reference arbitration from outstanding-read counts, scoreboard on outputs.
  always @(negedge clk) begin
    logic [1:0]  el, pg, sv, sr, mv, mr;
    logic [7:0]  sd [2];
    logic [15:0] md [2];
    logic [63:0] e;
    if (reset_p) begin
      check("reset_outputs", {s0_tready, s1_tready, ram_rd_en, ram_rd_addr, m0_tvalid, m1_tvalid,
                              m0_tdata, m1_tdata}, 64'd0);
      for (int c = 0; c < 2; c++) begin
        expq[c].delete();
        outst[c] = 0;
      end
      last_g = 1;
      hs = '0;
    end else begin
      sv = {s1_tvalid, s0_tvalid};  sr = {s1_tready, s0_tready};
      mv = {m1_tvalid, m0_tvalid};  mr = {m1_tready, m0_tready};
      sd[0] = s0_tdata;  sd[1] = s1_tdata;
      md[0] = m0_tdata;  md[1] = m1_tdata;
      for (int c = 0; c < 2; c++) el[c] = sv[c] && (outst[c] < CREDITS);
      if (el == 2'b11) pg = (last_g == 1) ? 2'b01 : 2'b10;
      else             pg = el;
      check("s_tready", sr, pg);
      check("ram_read", {ram_rd_en, ram_rd_addr},
            pg[0] ? {1'b1, s0_tdata} : (pg[1] ? {1'b1, s1_tdata} : 9'd0));
      check("overflow", {fifo1_overflow, fifo0_overflow}, 2'b00);
      if (pg != 2'b00) last_g = pg[1] ? 1 : 0;
      hs = sv & sr;
      for (int c = 0; c < 2; c++) begin
        if (hs[c]) begin
          expq[c].push_back(16'h1000 + {8'h00, sd[c]});
          outst[c]++;
          acc[c]++;
        end
        if (mv[c] && mr[c]) begin
          e = (expq[c].size() != 0) ? {48'd0, expq[c].pop_front()} : 64'h1_0000;
          check(c == 0 ? "m0_data" : "m1_data", {48'd0, md[c]}, e);
          outst[c]--;
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    s_prob = '{100, 100};
    m_prob = '{100, 100};
    while ((srcq[0].size() + srcq[1].size() + expq[0].size() + expq[1].size()) != 0 && n < 500)
    begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check(name, srcq[0].size() + srcq[1].size() + expq[0].size() + expq[1].size(), 0);
  endtask

  initial begin
    int base0, base1;
    bit got;
    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;

    // Single read with latency check.
    m_prob = '{100, 100};
    s_prob = '{100, 0};
    srcq[0].push_back(8'h05);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = s0_tvalid && s0_tready;
    end
    check("single_handshake", got, 1'b1);
    @(negedge clk);
    check("single_lat_n1", m0_tvalid, 1'b0);
    @(negedge clk);
    check("single_lat_n2", {m0_tvalid, m0_tdata}, {1'b1, 16'h1005});
    drain("single_drain");

    // Contention: both channels stream, grants alternate.
    for (int i = 0; i < 8; i++) begin
      srcq[0].push_back(8'(i));
      srcq[1].push_back(8'(8'h80 + i));
    end
    drain("contention_drain");

    // Back-pressure on m0: only CREDITS reads accepted, s1 unaffected.
    base0 = acc[0];
    base1 = acc[1];
    m_prob = '{0, 100};
    s_prob = '{100, 100};
    for (int i = 0; i < 10; i++) begin
      srcq[0].push_back(8'(8'h20 + i));
      srcq[1].push_back(8'(8'h40 + i));
    end
    repeat (20) @(posedge clk);
    check("bp_s0_accepted", acc[0] - base0, CREDITS);
    check("bp_s1_accepted", acc[1] - base1, 10);
    // Credit boundary: one pop re-opens s0 only on the following cycle.
    @(posedge clk);
    m_prob[0] = 100;
    @(negedge clk);
    check("credit_pop_cycle", {m0_tvalid, m0_tready, s0_tready}, 3'b110);
    @(posedge clk);
    m_prob[0] = 0;
    @(negedge clk);
    check("credit_next_cycle", s0_tready, 1'b1);
    drain("bp_drain");
    check("bp_s0_total", acc[0] - base0, 10);

    // Reset mid-burst with three reads outstanding on channel 0.
    base0 = acc[0];
    m_prob = '{0, 100};
    s_prob = '{100, 0};
    for (int i = 0; i < 3; i++) srcq[0].push_back(8'(8'h60 + i));
    repeat (6) @(posedge clk);
    check("rst_in_flight", acc[0] - base0, 3);
    #1 reset_p = 1'b1;
    srcq[0].delete();
    srcq[1].delete();
    @(posedge clk);
    #1 reset_p = 1'b0;
    @(negedge clk);
    check("rst_after", {m0_tvalid, fifo0_overflow, fifo1_overflow}, 3'b000);
    base0 = acc[0];
    for (int i = 0; i < 6; i++) srcq[0].push_back(8'(8'hA0 + i));
    repeat (12) @(posedge clk);
    check("rst_credits", acc[0] - base0, CREDITS);
    drain("rst_credit_drain");
    m_prob = '{100, 100};
    srcq[0].push_back(8'hFF);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = s0_tvalid && s0_tready;
    end
    check("rst_ff_handshake", got, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_ff_data", {m0_tvalid, m0_tdata}, {1'b1, 16'h10FF});
    drain("rst_ff_drain");

    // Random traffic on all four streams.
    for (int seg = 0; seg < 10; seg++) begin
      s_prob = '{$urandom_range(20, 100), $urandom_range(20, 100)};
      m_prob = '{$urandom_range(10, 100), $urandom_range(10, 100)};
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        for (int c = 0; c < 2; c++) while (srcq[c].size() < 4) srcq[c].push_back(8'($urandom));
      end
    end
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
